// File: rtl/zephyr_loader.sv
// zephyr_loader: streams a program into the zephyr CPU's program RAM and holds the CPU
// in reset until the load completes. Optional checksum stage: ZEPHYR_LOADER_CHECKSUM_EN.
module zephyr_loader #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int LOAD_LEN = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              start,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   byte_count
);

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_RUN   = 3'd2
`ifdef ZEPHYR_LOADER_CHECKSUM_EN
    ,
    ST_CHECK = 3'd3,
    ST_ERROR = 3'd4
`endif
  } state_t;

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(LOAD_LEN - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] CNT_ZERO = (ADDR_W+1)'(0);

  state_t              state_r;
  state_t              state_s;
  logic                ram_we_r;
  logic [ADDR_W-1:0]   ram_addr_r;
  logic [DATA_W-1:0]   ram_wdata_r;
  logic                cpu_reset_r;
  logic                done_r;
  logic [ADDR_W:0]     byte_count_r;
  logic                accept_s;
  logic                data_beat_s;
  logic                data_end_s;
  logic                restart_s;

`ifdef ZEPHYR_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]   sum_r;
  logic                sum_ok_s;
  logic                err_r;

  assign in_ready = (state_r == ST_LOAD) || (state_r == ST_CHECK);
  assign sum_ok_s = (sum_r == in_data);
  assign err      = err_r;
`else
  assign in_ready = (state_r == ST_LOAD);
  assign err      = 1'b0;
`endif

  assign accept_s    = in_valid && in_ready;
  assign data_beat_s = accept_s && (state_r == ST_LOAD);
  // The pointer never wraps: the beat at the last address always ends the load.
  assign data_end_s  = data_beat_s && (in_last || (byte_count_r == LAST_IDX));
  assign restart_s   = (state_r != ST_LOAD) && (state_s == ST_LOAD);

  assign ram_we     = ram_we_r;
  assign ram_addr   = ram_addr_r;
  assign ram_wdata  = ram_wdata_r;
  assign cpu_reset  = cpu_reset_r;
  assign done       = done_r;
  assign byte_count = byte_count_r;

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_LOAD: begin
        if (data_end_s) begin
`ifdef ZEPHYR_LOADER_CHECKSUM_EN
          state_s = ST_CHECK;
`else
          state_s = ST_FLUSH;
`endif
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_FLUSH: state_s = ST_RUN;
      ST_RUN: begin
        if (start) state_s = ST_LOAD;
        else       state_s = ST_RUN;
      end
`ifdef ZEPHYR_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (accept_s) state_s = sum_ok_s ? ST_RUN : ST_ERROR;
        else          state_s = ST_CHECK;
      end
      ST_ERROR: begin
        if (start) state_s = ST_LOAD;
        else       state_s = ST_ERROR;
      end
`endif
      default: state_s = ST_LOAD;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_LOAD;
    else       state_r <= state_s;
  end

  // RAM write port, byte counter and CPU control, all registered
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_we_r     <= 1'b0;
      ram_addr_r   <= {ADDR_W{1'b0}};
      ram_wdata_r  <= {DATA_W{1'b0}};
      byte_count_r <= CNT_ZERO;
      cpu_reset_r  <= 1'b1;
      done_r       <= 1'b0;
    end else begin
      ram_we_r    <= data_beat_s;
      cpu_reset_r <= (state_s != ST_RUN);
      done_r      <= (state_s == ST_RUN);
      if (data_beat_s) begin
        ram_addr_r   <= byte_count_r[ADDR_W-1:0];
        ram_wdata_r  <= in_data;
        byte_count_r <= byte_count_r + CNT_ONE;
      end else if (restart_s) begin
        byte_count_r <= CNT_ZERO;
      end else begin
        byte_count_r <= byte_count_r;
      end
    end
  end

`ifdef ZEPHYR_LOADER_CHECKSUM_EN
  // Running mod-256 sum of data bytes and the sticky checksum error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_r <= {DATA_W{1'b0}};
      err_r <= 1'b0;
    end else begin
      err_r <= (state_s == ST_ERROR);
      if (data_beat_s)    sum_r <= sum_r + in_data;
      else if (restart_s) sum_r <= {DATA_W{1'b0}};
      else                sum_r <= sum_r;
    end
  end
`endif

endmodule

// File: tb/tb_zephyr_loader.sv
// Self-checking bench for zephyr_loader: directed scenarios plus randomized loads,
// checked against a byte-level RAM model and a monitor-captured shadow of the RAM.
module tb_zephyr_loader;
  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic       start;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       cpu_reset;
  logic       done;
  logic       err;
  logic [4:0] byte_count;

  int checks = 0;
  int failures = 0;
  int exp_writes = 0;
  int seen_writes = 0;
  logic [7:0] model_ram [16];
  logic [7:0] shadow_ram [16];
  logic [7:0] bytes [16];

  zephyr_loader dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .start(start), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .cpu_reset(cpu_reset),
    .done(done), .err(err), .byte_count(byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM as the CPU sees it: latches the write strobe at each rising edge
  always @(posedge clk) begin
    if (ram_we === 1'b1) begin
      shadow_ram[ram_addr] <= ram_wdata;
      seen_writes <= seen_writes + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"}, ram_we, 0);
    check({tag, "_addr"}, ram_addr, 0);
    check({tag, "_wdata"}, ram_wdata, 0);
    check({tag, "_cpu"}, cpu_reset, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_count"}, byte_count, 0);
    check({tag, "_ready"}, in_ready, 1);
  endtask

  task automatic compare_ram(input string tag);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_ram%0d", tag, i), shadow_ram[i], model_ram[i]);
    check({tag, "_nwrites"}, seen_writes, exp_writes);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) bytes[i] = 8'($urandom);
  endtask

  // gaps: 0 = back-to-back, 1 = random idle cycles, 2 = idle before every beat
  task automatic send_data(input int n, input bit use_last, input int gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps == 2 || (gaps == 1 && $urandom_range(0, 1) == 1)) begin
        in_valid = 1'b0;
        step();
        check("gap_we", ram_we, 0);
      end
      in_valid = 1'b1;
      in_data  = bytes[i];
      in_last  = use_last && (i == n - 1);
      step();
      check("beat_we", ram_we, 1);
      check("beat_addr", ram_addr, i);
      check("beat_wdata", ram_wdata, bytes[i]);
      check("beat_count", byte_count, i + 1);
      model_ram[i] = bytes[i];
      exp_writes++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic finish_load(input int n, input bit bad);
    int sum = 0;
    logic [7:0] s;
    for (int i = 0; i < n; i++) sum += bytes[i];
    s = sum[7:0];
`ifdef ZEPHYR_LOADER_CHECKSUM_EN
    check("chk_ready", in_ready, 1);
    check("chk_cpu", cpu_reset, 1);
    in_valid = 1'b1;
    in_data  = bad ? s + 8'd1 : s;
    step();
    in_valid = 1'b0;
    check("chk_we", ram_we, 0);
    check("chk_count", byte_count, n);
    check("chk_ready_after", in_ready, 0);
    check("chk_err", err, bad);
    check("chk_cpu_after", cpu_reset, bad);
    check("chk_done", done, !bad);
`else
    check("end_ready", in_ready, 0);
    check("end_cpu", cpu_reset, 1);
    check("end_done", done, 0);
    step();
    check("run_we", ram_we, 0);
    check("run_cpu", cpu_reset, 0);
    check("run_done", done, 1);
    check("run_count", byte_count, n);
    check("run_err", err, (bad && 1'b0));
`endif
    compare_ram("ram");
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_cpu", cpu_reset, 1);
    check("start_done", done, 0);
    check("start_err", err, 0);
    check("start_ready", in_ready, 1);
    check("start_count", byte_count, 0);
  endtask

  task automatic set_t1_bytes();
    bytes[0] = 8'h00; bytes[1] = 8'h4F; bytes[2] = 8'h33; bytes[3] = 8'h3F;
  endtask

  initial begin
    int n;
    bit use_last;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    step();
    step();
    check_reset_vals("rst");
    reset = 1'b0;
    step();
    check("ready_after_rst", in_ready, 1);

    // basic four-byte load with IN_LAST
    set_t1_bytes();
    send_data(4, 1'b1, 0);
    finish_load(4, 1'b0);
    step();
    check("run_static_done", done, 1);
    check("run_static_we", ram_we, 0);

    // full-length load ends without IN_LAST; extra byte ignored
    pulse_start();
    for (int i = 0; i < 16; i++) bytes[i] = 8'(8'h10 + i);
    send_data(16, 1'b0, 0);
    finish_load(16, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    step();
    step();
    in_valid = 1'b0;
    check("extra_we", ram_we, 0);
    check("extra_count", byte_count, 16);
    check("extra_ready", in_ready, 0);
    compare_ram("extra");

    // same bytes as the first load with idle cycles between beats
    pulse_start();
    set_t1_bytes();
    send_data(4, 1'b1, 2);
    finish_load(4, 1'b0);

    // reset in the middle of a load restarts at address 0
    pulse_start();
    fill_random(2);
    send_data(2, 1'b0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_vals("midrst");
    set_t1_bytes();
    send_data(4, 1'b1, 0);
    finish_load(4, 1'b0);

    // reset and start together: reset wins and clears the address register
    reset = 1'b1;
    start = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    check_reset_vals("rst_start");

    // short reload leaves the upper addresses untouched
    fill_random(16);
    send_data(16, 1'b0, 1);
    finish_load(16, 1'b0);
    pulse_start();
    fill_random(8);
    send_data(8, 1'b1, 0);
    finish_load(8, 1'b0);

`ifdef ZEPHYR_LOADER_CHECKSUM_EN
    // checksum good then bad; START recovers from the error
    pulse_start();
    bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03;
    send_data(3, 1'b1, 0);
    finish_load(3, 1'b0);
    pulse_start();
    send_data(3, 1'b1, 0);
    finish_load(3, 1'b1);
    step();
    check("err_hold", err, 1);
    check("err_cpu_hold", cpu_reset, 1);
`endif

    // randomized loads
    for (int k = 0; k < 10; k++) begin
      pulse_start();
      n = $urandom_range(1, 16);
      fill_random(n);
      use_last = (n < 16) ? 1'b1 : 1'($urandom_range(0, 1));
      send_data(n, use_last, $urandom_range(0, 2));
      finish_load(n, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
